// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI bus arbiter between the
// inertial-sensor and A2D interfaces.
package spi_arb_pkg;

    localparam int unsigned CMD_W          = 16;
    localparam int unsigned STREAK_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 1024;

    typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} arb_state_t;
    typedef enum logic {OWN_INERT, OWN_A2D} owner_t;

endpackage

// File: rtl/spi_arb.sv
// Shares one SPI master between the inertial and A2D interfaces: grants the bus,
// fires wrt, returns read data/done to the owner, and aborts hung transactions.
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned STREAK_MAX = STREAK_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_inert,
    input  logic [CMD_W-1:0] cmd_inert,
    input  logic             lock_inert,
    input  logic             req_a2d,
    input  logic [CMD_W-1:0] cmd_a2d,
    input  logic             lock_a2d,
    input  logic             spi_done,
    input  logic [CMD_W-1:0] spi_rd,
    output logic             wrt,
    output logic [CMD_W-1:0] cmd,
    output logic             sel_a2d,
    output logic             gnt_inert,
    output logic             gnt_a2d,
    output logic             done_inert,
    output logic             done_a2d,
    output logic [CMD_W-1:0] rd_data,
    output logic             err
);

    localparam int unsigned STREAK_W = $clog2(STREAK_MAX + 1);
    localparam int unsigned TIMER_W  = $clog2(TIMEOUT);

    arb_state_t          state_q,      state_d;
    owner_t              owner_q,      owner_d;
    logic [CMD_W-1:0]    cmd_q,        cmd_d;
    logic [CMD_W-1:0]    rd_data_q,    rd_data_d;
    logic                gnt_inert_q,  gnt_inert_d;
    logic                gnt_a2d_q,    gnt_a2d_d;
    logic                wrt_q,        wrt_d;
    logic                done_inert_q, done_inert_d;
    logic                done_a2d_q,   done_a2d_d;
    logic                err_q,        err_d;
    logic [STREAK_W-1:0] streak_q,     streak_d;
    logic [TIMER_W-1:0]  timer_q,      timer_d;

    logic own_req;
    logic own_lock;
    logic a2d_wins;

    assign own_req  = (owner_q == OWN_A2D) ? req_a2d  : req_inert;
    assign own_lock = (owner_q == OWN_A2D) ? lock_a2d : lock_inert;
    // Inertial has priority until it has starved a waiting A2D for STREAK_MAX grants.
    assign a2d_wins = req_a2d && (!req_inert || (streak_q >= STREAK_W'(STREAK_MAX)));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        rd_data_d    = rd_data_q;
        gnt_inert_d  = gnt_inert_q;
        gnt_a2d_d    = gnt_a2d_q;
        streak_d     = streak_q;
        timer_d      = timer_q;
        wrt_d        = 1'b0;
        done_inert_d = 1'b0;
        done_a2d_d   = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!req_a2d) begin
                    streak_d = '0;
                end
                if (a2d_wins) begin
                    owner_d   = OWN_A2D;
                    cmd_d     = cmd_a2d;
                    gnt_a2d_d = 1'b1;
                    streak_d  = '0;
                    timer_d   = '0;
                    wrt_d     = 1'b1;
                    state_d   = START;
                end else if (req_inert) begin
                    owner_d     = OWN_INERT;
                    cmd_d       = cmd_inert;
                    gnt_inert_d = 1'b1;
                    timer_d     = '0;
                    wrt_d       = 1'b1;
                    state_d     = START;
                    if (req_a2d && (streak_q < STREAK_W'(STREAK_MAX))) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end

            // Timer counts cycles since the wrt cycle, so err lands TIMEOUT cycles after wrt.
            START: begin
                timer_d = TIMER_W'(1);
                state_d = BUSY;
            end

            BUSY: begin
                timer_d = timer_q + 1'b1;
                if (spi_done) begin
                    rd_data_d    = spi_rd;
                    done_a2d_d   = (owner_q == OWN_A2D);
                    done_inert_d = (owner_q == OWN_INERT);
                    if (own_lock) begin
                        state_d = HOLD;
                    end else begin
                        gnt_inert_d = 1'b0;
                        gnt_a2d_d   = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    gnt_inert_d = 1'b0;
                    gnt_a2d_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            // Owner keeps the bus; the other requester is not looked at here.
            HOLD: begin
                if (own_req) begin
                    cmd_d   = (owner_q == OWN_A2D) ? cmd_a2d : cmd_inert;
                    timer_d = '0;
                    wrt_d   = 1'b1;
                    state_d = START;
                end else if (!own_lock) begin
                    gnt_inert_d = 1'b0;
                    gnt_a2d_d   = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INERT;
            cmd_q        <= '0;
            rd_data_q    <= '0;
            gnt_inert_q  <= 1'b0;
            gnt_a2d_q    <= 1'b0;
            wrt_q        <= 1'b0;
            done_inert_q <= 1'b0;
            done_a2d_q   <= 1'b0;
            err_q        <= 1'b0;
            streak_q     <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            rd_data_q    <= rd_data_d;
            gnt_inert_q  <= gnt_inert_d;
            gnt_a2d_q    <= gnt_a2d_d;
            wrt_q        <= wrt_d;
            done_inert_q <= done_inert_d;
            done_a2d_q   <= done_a2d_d;
            err_q        <= err_d;
            streak_q     <= streak_d;
            timer_q      <= timer_d;
        end
    end

    assign wrt        = wrt_q;
    assign cmd        = cmd_q;
    assign sel_a2d    = (owner_q == OWN_A2D);
    assign gnt_inert  = gnt_inert_q;
    assign gnt_a2d    = gnt_a2d_q;
    assign done_inert = done_inert_q;
    assign done_a2d   = done_a2d_q;
    assign rd_data    = rd_data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: default instance plus a TIMEOUT=16 instance sharing inputs.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_inert, lock_inert, req_a2d, lock_a2d, spi_done;
    logic [15:0] cmd_inert, cmd_a2d, spi_rd;

    logic        wrt, sel_a2d, gnt_inert, gnt_a2d, done_inert, done_a2d, err;
    logic [15:0] cmd, rd_data;

    logic        t_wrt, t_sel_a2d, t_gnt_inert, t_gnt_a2d, t_done_inert, t_done_a2d, t_err;
    logic [15:0] t_cmd, t_rd_data;

    int checks = 0;
    int passed = 0;
    int n_done_inert = 0;
    int n_inert_starts = 0;

    always #5 clk = ~clk;

    spi_arb dut (
        .clk(clk), .rst(rst),
        .req_inert(req_inert), .cmd_inert(cmd_inert), .lock_inert(lock_inert),
        .req_a2d(req_a2d), .cmd_a2d(cmd_a2d), .lock_a2d(lock_a2d),
        .spi_done(spi_done), .spi_rd(spi_rd),
        .wrt(wrt), .cmd(cmd), .sel_a2d(sel_a2d),
        .gnt_inert(gnt_inert), .gnt_a2d(gnt_a2d),
        .done_inert(done_inert), .done_a2d(done_a2d),
        .rd_data(rd_data), .err(err)
    );

    spi_arb #(.STREAK_MAX(4), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst),
        .req_inert(req_inert), .cmd_inert(cmd_inert), .lock_inert(lock_inert),
        .req_a2d(req_a2d), .cmd_a2d(cmd_a2d), .lock_a2d(lock_a2d),
        .spi_done(spi_done), .spi_rd(spi_rd),
        .wrt(t_wrt), .cmd(t_cmd), .sel_a2d(t_sel_a2d),
        .gnt_inert(t_gnt_inert), .gnt_a2d(t_gnt_a2d),
        .done_inert(t_done_inert), .done_a2d(t_done_a2d),
        .rd_data(t_rd_data), .err(t_err)
    );

    always @(negedge clk) begin
        if (done_inert === 1'b1) n_done_inert++;
        if (wrt === 1'b1 && gnt_inert === 1'b1) n_inert_starts++;
    end

    task automatic run_spi(input int n, input logic [15:0] rd);
        repeat (n) @(negedge clk);
        spi_done = 1'b1;
        spi_rd   = rd;
        @(negedge clk);
        spi_done = 1'b0;
        spi_rd   = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_inert = 1'b0; lock_inert = 1'b0; cmd_inert = 16'h0000;
        req_a2d = 1'b0; lock_a2d = 1'b0; cmd_a2d = 16'h0000;
        spi_done = 1'b0; spi_rd = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, err, sel_a2d} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected %b",
                     {wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, err, sel_a2d}, 7'b0);
        else passed++;
        checks++;
        if ({cmd, rd_data} !== 32'h0)
            $display("FAIL reset_data: got %h expected %h", {cmd, rd_data}, 32'h0);
        else passed++;
        checks++;
        if ({t_wrt, t_gnt_inert, t_gnt_a2d, t_done_inert, t_done_a2d, t_err, t_sel_a2d} !== 7'b0)
            $display("FAIL reset_ctrl_to: got %b expected %b",
                     {t_wrt, t_gnt_inert, t_gnt_a2d, t_done_inert, t_done_a2d, t_err, t_sel_a2d}, 7'b0);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int di0;
        di0 = n_done_inert;
        req_a2d = 1'b1; cmd_a2d = 16'h0C00;
        @(negedge clk);
        checks++;
        if ({wrt, sel_a2d, gnt_inert, gnt_a2d} !== 4'b1101)
            $display("FAIL single_start: got %b expected %b", {wrt, sel_a2d, gnt_inert, gnt_a2d}, 4'b1101);
        else passed++;
        checks++;
        if (cmd !== 16'h0C00) $display("FAIL single_cmd: got %h expected %h", cmd, 16'h0C00);
        else passed++;
        @(negedge clk);
        checks++;
        if (wrt !== 1'b0) $display("FAIL single_wrt_pulse: got %b expected %b", wrt, 1'b0);
        else passed++;
        run_spi(18, 16'h0ABC);
        checks++;
        if ({done_a2d, gnt_a2d} !== 2'b10)
            $display("FAIL single_done: got %b expected %b", {done_a2d, gnt_a2d}, 2'b10);
        else passed++;
        checks++;
        if (rd_data !== 16'h0ABC) $display("FAIL single_rd: got %h expected %h", rd_data, 16'h0ABC);
        else passed++;
        req_a2d = 1'b0; cmd_a2d = 16'h0000;
        @(negedge clk);
        checks++;
        if (done_a2d !== 1'b0) $display("FAIL single_done_pulse: got %b expected %b", done_a2d, 1'b0);
        else passed++;
        #1;
        checks++;
        if (n_done_inert - di0 !== 0)
            $display("FAIL single_no_done_inert: got %0d expected %0d", n_done_inert - di0, 0);
        else passed++;
    endtask

    task automatic test_simultaneous();
        req_inert = 1'b1; cmd_inert = 16'h1111;
        req_a2d = 1'b1; cmd_a2d = 16'h2222;
        @(negedge clk);
        checks++;
        if ({wrt, sel_a2d, gnt_inert, gnt_a2d, cmd} !== {4'b1010, 16'h1111})
            $display("FAIL simul_first: got %h expected %h", {wrt, sel_a2d, gnt_inert, gnt_a2d, cmd},
                     {4'b1010, 16'h1111});
        else passed++;
        run_spi(3, 16'h5555);
        checks++;
        if ({done_inert, done_a2d, gnt_inert, rd_data} !== {3'b100, 16'h5555})
            $display("FAIL simul_done_inert: got %h expected %h", {done_inert, done_a2d, gnt_inert, rd_data},
                     {3'b100, 16'h5555});
        else passed++;
        req_inert = 1'b0;
        @(negedge clk);
        checks++;
        if ({wrt, sel_a2d, gnt_inert, gnt_a2d, cmd} !== {4'b1101, 16'h2222})
            $display("FAIL simul_second: got %h expected %h", {wrt, sel_a2d, gnt_inert, gnt_a2d, cmd},
                     {4'b1101, 16'h2222});
        else passed++;
        run_spi(3, 16'h6666);
        checks++;
        if ({done_a2d, rd_data} !== {1'b1, 16'h6666})
            $display("FAIL simul_done_a2d: got %h expected %h", {done_a2d, rd_data}, {1'b1, 16'h6666});
        else passed++;
        req_a2d = 1'b0;
    endtask

    task automatic test_streak();
        req_inert = 1'b1; cmd_inert = 16'hAAAA;
        req_a2d = 1'b1; cmd_a2d = 16'hBBBB;
        for (int g = 0; g < 10; g++) begin
            logic exp_a2d;
            int   waited;
            exp_a2d = (g == 4) || (g == 9);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (wrt !== 1'b1 && waited < 8);
            checks++;
            if (wrt !== 1'b1) $display("FAIL streak_wrt_timeout[%0d]: got %b expected %b", g, wrt, 1'b1);
            else passed++;
            checks++;
            if ({gnt_a2d, sel_a2d} !== {exp_a2d, exp_a2d})
                $display("FAIL streak_owner[%0d]: got %b expected %b", g, {gnt_a2d, sel_a2d}, {exp_a2d, exp_a2d});
            else passed++;
            run_spi(2, 16'(g));
        end
        req_inert = 1'b0; req_a2d = 1'b0;
    endtask

    task automatic test_lock();
        int s0;
        req_a2d = 1'b1; lock_a2d = 1'b1; cmd_a2d = 16'h0C08;
        @(negedge clk);
        checks++;
        if ({gnt_a2d, wrt, cmd} !== {2'b11, 16'h0C08})
            $display("FAIL lock_first: got %h expected %h", {gnt_a2d, wrt, cmd}, {2'b11, 16'h0C08});
        else passed++;
        req_inert = 1'b1; cmd_inert = 16'h3333;
        #1 s0 = n_inert_starts;
        run_spi(4, 16'h0111);
        checks++;
        if ({done_a2d, gnt_inert, gnt_a2d} !== 3'b101)
            $display("FAIL lock_hold: got %b expected %b", {done_a2d, gnt_inert, gnt_a2d}, 3'b101);
        else passed++;
        cmd_a2d = 16'h0C10;
        @(negedge clk);
        checks++;
        if ({wrt, sel_a2d, gnt_inert, gnt_a2d, cmd} !== {4'b1101, 16'h0C10})
            $display("FAIL lock_second: got %h expected %h", {wrt, sel_a2d, gnt_inert, gnt_a2d, cmd},
                     {4'b1101, 16'h0C10});
        else passed++;
        run_spi(4, 16'h0222);
        checks++;
        if ({done_a2d, gnt_inert, gnt_a2d, rd_data} !== {3'b101, 16'h0222})
            $display("FAIL lock_done2: got %h expected %h", {done_a2d, gnt_inert, gnt_a2d, rd_data},
                     {3'b101, 16'h0222});
        else passed++;
        lock_a2d = 1'b0; req_a2d = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt_inert, gnt_a2d, wrt} !== 3'b000)
            $display("FAIL lock_release: got %b expected %b", {gnt_inert, gnt_a2d, wrt}, 3'b000);
        else passed++;
        #1;
        checks++;
        if (n_inert_starts - s0 !== 0)
            $display("FAIL lock_no_inert: got %0d expected %0d", n_inert_starts - s0, 0);
        else passed++;
        @(negedge clk);
        checks++;
        if ({wrt, sel_a2d, gnt_inert, gnt_a2d, cmd} !== {4'b1010, 16'h3333})
            $display("FAIL lock_inert_after: got %h expected %h", {wrt, sel_a2d, gnt_inert, gnt_a2d, cmd},
                     {4'b1010, 16'h3333});
        else passed++;
        run_spi(2, 16'h0333);
        req_inert = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int t_dones;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_inert = 1'b1; cmd_inert = 16'h4444;
        @(negedge clk);
        checks++;
        if ({t_wrt, t_gnt_inert} !== 2'b11)
            $display("FAIL timeout_start: got %b expected %b", {t_wrt, t_gnt_inert}, 2'b11);
        else passed++;
        n = 0;
        t_dones = 0;
        while (t_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (t_done_inert === 1'b1 || t_done_a2d === 1'b1) t_dones++;
        end
        checks++;
        if (n !== 16) $display("FAIL timeout_latency: got %0d expected %0d", n, 16);
        else passed++;
        checks++;
        if (t_dones !== 0) $display("FAIL timeout_no_done: got %0d expected %0d", t_dones, 0);
        else passed++;
        checks++;
        if ({t_gnt_inert, t_gnt_a2d} !== 2'b00)
            $display("FAIL timeout_gnt: got %b expected %b", {t_gnt_inert, t_gnt_a2d}, 2'b00);
        else passed++;
        req_inert = 1'b0;
        @(negedge clk);
        checks++;
        if ({t_err, t_wrt, t_gnt_inert} !== 3'b000)
            $display("FAIL timeout_idle: got %b expected %b", {t_err, t_wrt, t_gnt_inert}, 3'b000);
        else passed++;
    endtask

    task automatic test_reset_busy();
        checks++;
        if ({gnt_inert, wrt, cmd} !== {2'b10, 16'h4444})
            $display("FAIL rstbusy_pre: got %h expected %h", {gnt_inert, wrt, cmd}, {2'b10, 16'h4444});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, err, sel_a2d, cmd, rd_data} !== 39'h0)
            $display("FAIL rstbusy_outputs: got %h expected %h",
                     {wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, err, sel_a2d, cmd, rd_data}, 39'h0);
        else passed++;
        rst = 1'b0;
        spi_done = 1'b1; spi_rd = 16'hDEAD;
        @(negedge clk);
        spi_done = 1'b0; spi_rd = 16'h0000;
        checks++;
        if ({done_inert, done_a2d, rd_data} !== 18'h0)
            $display("FAIL rstbusy_late_done: got %h expected %h", {done_inert, done_a2d, rd_data}, 18'h0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_streak();
        test_lock();
        test_timeout();
        test_reset_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1);
    end

endmodule
